// File: rtl/button_press_classifier.sv
// Synchronises, debounces and classifies one push-button into short/long increment pulses; outputs are registered, pulses land 1 clk after the deciding tick.
// Optional AUTO_REPEAT_EN: repeated inc_long every REPEAT_TICKS while the long press is held.
module button_press_classifier #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200,
    parameter int CNT_W          = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic pressed,
    output logic inc_short,
    output logic inc_long
);

    if ((2 ** CNT_W) <= LONG_TICKS || (2 ** CNT_W) <= DEBOUNCE_TICKS || (2 ** CNT_W) <= REPEAT_TICKS) begin : g_bad_cnt_w
        $error("CNT_W too narrow for the configured tick thresholds");
    end

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        HELD        = 3'd2,
        LONG_HELD   = 3'd3,
        DEB_RELEASE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEB_T  = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic             sync_q, btn_s;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             long_seen_q, long_seen_d;
    logic             pressed_d, inc_short_d, inc_long_d;
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_T = CNT_W'(REPEAT_TICKS);
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= 1'b0;
            btn_s       <= 1'b0;
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_seen_q <= 1'b0;
            pressed     <= 1'b0;
            inc_short   <= 1'b0;
            inc_long    <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            sync_q      <= btn_raw;
            btn_s       <= sync_q;
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_seen_q <= long_seen_d;
            pressed     <= pressed_d;
            inc_short   <= inc_short_d;
            inc_long    <= inc_long_d;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    // The btn_s checks come before the tick checks so that a tick coinciding with a level change is never counted as hold.
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_seen_d = long_seen_q;
        pressed_d   = pressed;
        inc_short_d = 1'b0;
        inc_long_d  = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = '0;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (tick) begin
                    deb_cnt_d = deb_cnt_q + ONE;
                    if (deb_cnt_q + ONE == DEB_T) begin
                        state_d    = HELD;
                        pressed_d  = 1'b1;
                        hold_cnt_d = '0;
                    end
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d   = DEB_RELEASE;
                    deb_cnt_d = '0;
                end else if (tick) begin
                    hold_cnt_d = hold_cnt_q + ONE;
                    if (hold_cnt_q + ONE == LONG_T) begin
                        state_d     = LONG_HELD;
                        inc_long_d  = 1'b1;
                        long_seen_d = 1'b1;
`ifdef AUTO_REPEAT_EN
                        rep_cnt_d   = '0;
`endif
                    end
                end
            end
            LONG_HELD: begin
                if (!btn_s) begin
                    state_d   = DEB_RELEASE;
                    deb_cnt_d = '0;
                end
`ifdef AUTO_REPEAT_EN
                else if (tick) begin
                    if (rep_cnt_q + ONE == REP_T) begin
                        inc_long_d = 1'b1;
                        rep_cnt_d  = '0;
                    end else begin
                        rep_cnt_d  = rep_cnt_q + ONE;
                    end
                end
`endif
            end
            DEB_RELEASE: begin
                if (btn_s) begin
                    state_d = long_seen_q ? LONG_HELD : HELD;
                end else if (tick) begin
                    deb_cnt_d = deb_cnt_q + ONE;
                    if (deb_cnt_q + ONE == DEB_T) begin
                        state_d     = IDLE;
                        pressed_d   = 1'b0;
                        inc_short_d = !long_seen_q;
                        long_seen_d = 1'b0;
                        hold_cnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
